avst_frame_capture: RTL and testbench

Avalon-ST video sink that accepts the 640x480, 30-bit RGB pixel stream produced by the face/filter sources and stores a 4x-downscaled 160x120, 12-bit copy in an internal frame store. It checks packet framing and reports frame completion and framing errors. A host-side read port exposes the stored frame, for loopback verification of the video sources and for later processing stages.

---
 rtl/vga_pkg.sv | 19 +
 rtl/frame_store_ram.sv | 24 ++
 rtl/avst_frame_capture.sv | 170 +++++++++++++++++
 tb/tb_avst_frame_capture.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared video constants, the stored pixel type and the capture state encoding.
package vga_pkg;

    localparam int unsigned VGA_WIDTH   = 640;
    localparam int unsigned VGA_HEIGHT  = 480;
    localparam int unsigned SRC_WIDTH   = 160;
    localparam int unsigned SRC_HEIGHT  = 120;
    localparam int unsigned STORE_DEPTH = SRC_WIDTH * SRC_HEIGHT;
    localparam int unsigned STORE_AW    = 15;

    typedef logic [11:0] pixel12_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOP,
        ST_CAPTURE
    } capture_state_t;

endpackage

// File: rtl/frame_store_ram.sv
// Simple dual-port frame store: one write port, one registered read port (read-old on collision).
module frame_store_ram #(
    parameter int unsigned DEPTH = vga_pkg::STORE_DEPTH,
    parameter int unsigned AW    = vga_pkg::STORE_AW
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [11:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [11:0]   rd_data
);
    import vga_pkg::*;

    pixel12_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/avst_frame_capture.sv
// Avalon-ST video sink: framing checks plus a SCALE-downscaled 12-bit frame store.
// Define AVST_CAPTURE_AVG_EN to store the rounded horizontal mean instead of decimating.
module avst_frame_capture #(
    parameter int unsigned VGA_WIDTH  = vga_pkg::VGA_WIDTH,
    parameter int unsigned VGA_HEIGHT = vga_pkg::VGA_HEIGHT,
    parameter int unsigned SCALE      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] data,
    input  logic        startofpacket,
    input  logic        endofpacket,
    input  logic        valid,
    output logic        ready,
    input  logic        arm,
    input  logic [14:0] rd_addr,
    output logic [11:0] rd_data,
    output logic        frame_done,
    output logic        err_short,
    output logic        err_long,
    input  logic        err_clear,
    output logic [7:0]  frame_count
);
    import vga_pkg::*;

    localparam int unsigned XW        = $clog2(VGA_WIDTH);
    localparam int unsigned YW        = $clog2(VGA_HEIGHT);
    localparam int unsigned LOG2S     = $clog2(SCALE);
    localparam int unsigned ROW_WORDS = VGA_WIDTH / SCALE;
    localparam logic [XW-1:0] X_LAST  = XW'(VGA_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(VGA_HEIGHT - 1);
    localparam logic [XW-1:0] X_MASK  = XW'(SCALE - 1);
    localparam logic [YW-1:0] Y_MASK  = YW'(SCALE - 1);

    capture_state_t        state;
    logic [XW-1:0]         x_cnt, cur_x;
    logic [YW-1:0]         y_cnt, cur_y;
    logic                  accept, restart, in_frame, at_last;
    logic                  sop_err, short_evt, long_evt, store_now;
    logic [STORE_AW-1:0]   addr_now;
    pixel12_t              pix_now;
    logic                  wr_en;
    logic [STORE_AW-1:0]   wr_addr;
    pixel12_t              wr_data;
    logic                  unused_data;

    assign unused_data = ^{data[25:20], data[15:10], data[5:0]};

    // An accepted SOP always restarts the pixel position at 0, whatever the counters say.
    always_comb begin
        accept    = valid & ready;
        restart   = (state == ST_WAIT_SOP) || startofpacket;
        in_frame  = accept && ((state == ST_CAPTURE) ||
                               ((state == ST_WAIT_SOP) && startofpacket));
        cur_x     = restart ? '0 : x_cnt;
        cur_y     = restart ? '0 : y_cnt;
        at_last   = (cur_x == X_LAST) && (cur_y == Y_LAST);
        sop_err   = (state == ST_CAPTURE) && startofpacket &&
                    ((x_cnt != '0) || (y_cnt != '0));
        short_evt = in_frame && ((endofpacket && !at_last) || sop_err);
        long_evt  = in_frame && !endofpacket && at_last;
        addr_now  = STORE_AW'(32'(cur_y >> LOG2S) * ROW_WORDS + 32'(cur_x >> LOG2S));
    end

`ifdef AVST_CAPTURE_AVG_EN
    localparam int unsigned SW = 4 + LOG2S;

    logic [SW-1:0] acc_r, acc_g, acc_b;
    logic [SW-1:0] sum_r, sum_g, sum_b;
    logic [SW-1:0] rnd_r, rnd_g, rnd_b;
    logic          group_first;

    always_comb begin
        group_first = (cur_x & X_MASK) == '0;
        sum_r       = (group_first ? '0 : acc_r) + SW'(data[29:26]);
        sum_g       = (group_first ? '0 : acc_g) + SW'(data[19:16]);
        sum_b       = (group_first ? '0 : acc_b) + SW'(data[9:6]);
        rnd_r       = sum_r + SW'(SCALE / 2);
        rnd_g       = sum_g + SW'(SCALE / 2);
        rnd_b       = sum_b + SW'(SCALE / 2);
        store_now   = in_frame && ((cur_y & Y_MASK) == '0) && ((cur_x & X_MASK) == X_MASK);
        pix_now     = {rnd_r[SW-1:LOG2S], rnd_g[SW-1:LOG2S], rnd_b[SW-1:LOG2S]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else if (in_frame) begin
            acc_r <= sum_r;
            acc_g <= sum_g;
            acc_b <= sum_b;
        end
    end
`else
    always_comb begin
        store_now = in_frame && ((cur_y & Y_MASK) == '0) && ((cur_x & X_MASK) == '0);
        pix_now   = {data[29:26], data[19:16], data[9:6]};
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            x_cnt       <= '0;
            y_cnt       <= '0;
            ready       <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            frame_count <= '0;
        end else begin
            ready      <= 1'b1;
            wr_en      <= store_now;
            wr_addr    <= addr_now;
            wr_data    <= pix_now;
            frame_done <= 1'b0;
            err_short  <= short_evt | (err_short & ~err_clear);
            err_long   <= long_evt  | (err_long  & ~err_clear);

            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state <= ST_WAIT_SOP;
                    end
                end
                ST_WAIT_SOP, ST_CAPTURE: begin
                    if (in_frame) begin
                        if (endofpacket) begin
                            if (at_last) begin
                                frame_done  <= 1'b1;
                                frame_count <= frame_count + 8'd1;
                            end
                            state <= arm ? ST_WAIT_SOP : ST_IDLE;
                        end else if (at_last) begin
                            state <= ST_WAIT_SOP;
                        end else begin
                            state <= ST_CAPTURE;
                            if (cur_x == X_LAST) begin
                                x_cnt <= '0;
                                y_cnt <= cur_y + 1'b1;
                            end else begin
                                x_cnt <= cur_x + 1'b1;
                                y_cnt <= cur_y;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    frame_store_ram #(
        .DEPTH (STORE_DEPTH),
        .AW    (STORE_AW)
    ) u_store (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_avst_frame_capture.sv
// Directed/randomized bench for avst_frame_capture on a reduced 32x16 frame.
module tb_avst_frame_capture;

    localparam int unsigned W     = 32;
    localparam int unsigned H     = 16;
    localparam int unsigned S     = 4;
    localparam int unsigned NPIX  = W * H;
    localparam int unsigned WORDS = (W / S) * (H / S);

    logic        clk = 1'b0;
    logic        reset_n;
    logic [29:0] data;
    logic        startofpacket, endofpacket, valid, ready, arm;
    logic [14:0] rd_addr;
    logic [11:0] rd_data;
    logic        frame_done, err_short, err_long, err_clear;
    logic [7:0]  frame_count;

    int unsigned passes = 0;
    int unsigned total  = 0;
    int unsigned done_pulses = 0;
    int unsigned exp_pulses  = 0;
    logic [7:0]  exp_count = 8'd0;
    bit          gaps = 1'b0;

    logic [29:0] frame_pix [NPIX];
    logic [11:0] exp_mem   [WORDS];
    bit          written   [WORDS];

    avst_frame_capture #(
        .VGA_WIDTH  (W),
        .VGA_HEIGHT (H),
        .SCALE      (S)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .data          (data),
        .startofpacket (startofpacket),
        .endofpacket   (endofpacket),
        .valid         (valid),
        .ready         (ready),
        .arm           (arm),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .frame_done    (frame_done),
        .err_short     (err_short),
        .err_long      (err_long),
        .err_clear     (err_clear),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_pulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: which pixels of a captured run land in the store, and with what value.
    task automatic model_capture(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            int unsigned x, y, a;
            x = i % W;
            y = i / W;
            a = (y / S) * (W / S) + x / S;
            if (y % S == 0) begin
`ifdef AVST_CAPTURE_AVG_EN
                if (x % S == S - 1) begin
                    int unsigned sr, sg, sb;
                    sr = 0; sg = 0; sb = 0;
                    for (int unsigned j = 0; j < S; j++) begin
                        sr += 32'(frame_pix[i-j][29:26]);
                        sg += 32'(frame_pix[i-j][19:16]);
                        sb += 32'(frame_pix[i-j][9:6]);
                    end
                    exp_mem[a] = {4'((sr + S/2) / S), 4'((sg + S/2) / S), 4'((sb + S/2) / S)};
                    written[a] = 1'b1;
                end
`else
                if (x % S == 0) begin
                    exp_mem[a] = {frame_pix[i][29:26], frame_pix[i][19:16], frame_pix[i][9:6]};
                    written[a] = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic drive_frame(input int unsigned n, input bit with_sop, input bit with_eop,
                               input bit captured, input bit ramp, input bit clr_last);
        logic [29:0] d;
        bit          exp_done;
        for (int unsigned i = 0; i < n; i++) begin
            d = 30'($urandom);
            if (ramp) begin
                d[29:26] = 4'(i % W);
                d[19:16] = 4'(i / W);
            end
            frame_pix[i] = d;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            valid         = 1'b1;
            data          = d;
            startofpacket = with_sop && (i == 0);
            endofpacket   = with_eop && (i == n - 1);
            err_clear     = clr_last && (i == n - 1);
            @(posedge clk); #1;
            valid         = 1'b0;
            startofpacket = 1'b0;
            endofpacket   = 1'b0;
            err_clear     = 1'b0;
        end
        if (captured) model_capture(n);
        exp_done = with_eop && captured && (n == NPIX);
        @(negedge clk);
        chk("frame_done_after_eop", {31'd0, frame_done}, {31'd0, exp_done});
        if (exp_done) begin
            exp_pulses++;
            exp_count = exp_count + 8'd1;
        end
        @(posedge clk); #1;
    endtask

    task automatic read_word(input int unsigned a, output logic [11:0] v);
        rd_addr = 15'(a);
        @(posedge clk); #1;
        v = rd_data;
    endtask

    task automatic check_store(input string tag);
        logic [11:0] v;
        for (int unsigned a = 0; a < WORDS; a++) begin
            if (written[a]) begin
                read_word(a, v);
                chk($sformatf("%s[%0d]", tag, a), {20'd0, v}, {20'd0, exp_mem[a]});
            end
        end
    endtask

    task automatic check_status(input string tag, input bit es, input bit el);
        chk({tag, "_count"}, {24'd0, frame_count}, {24'd0, exp_count});
        chk({tag, "_pulses"}, done_pulses, exp_pulses);
        chk({tag, "_err_short"}, {31'd0, err_short}, {31'd0, es});
        chk({tag, "_err_long"}, {31'd0, err_long}, {31'd0, el});
    endtask

    initial begin
        logic [11:0] v;
        logic [3:0]  bn;
        reset_n = 1'b0; arm = 1'b0; valid = 1'b0; data = '0;
        startofpacket = 1'b0; endofpacket = 1'b0; err_clear = 1'b0; rd_addr = '0;
        for (int unsigned a = 0; a < WORDS; a++) written[a] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
        check_status("reset", 1'b0, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", {31'd0, ready}, 32'd1);

        // Ramp frame
        arm = 1'b1;
        @(posedge clk); #1;
        drive_frame(NPIX, 1, 1, 1, 1, 0);
        check_status("ramp", 1'b0, 1'b0);
        bn = exp_mem[W/S + 1][3:0];
        read_word(W/S + 1, v);
`ifdef AVST_CAPTURE_AVG_EN
        chk("ramp_word_1_1", {20'd0, v}, {20'd0, 4'h6, 4'h4, bn});
`else
        bn = frame_pix[S*W + S][9:6];
        chk("ramp_word_1_1", {20'd0, v}, {20'd0, 4'h4, 4'h4, bn});
`endif
        check_store("ramp_store");

        // Two back-to-back random frames with valid gaps
        gaps = 1'b1;
        drive_frame(NPIX, 1, 1, 1, 0, 0);
        drive_frame(NPIX, 1, 1, 1, 0, 0);
        gaps = 1'b0;
        check_status("b2b", 1'b0, 1'b0);
        check_store("b2b_store");

        // Short frame: EOP at index 100, err_clear coincident with the event
        drive_frame(101, 1, 1, 1, 0, 1);
        check_status("short", 1'b1, 1'b0);
        drive_frame(NPIX, 1, 1, 1, 0, 0);
        check_status("after_short", 1'b1, 1'b0);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        check_status("cleared", 1'b0, 1'b0);

        // SOP at index 200 restarts the frame
        drive_frame(200, 1, 0, 1, 0, 0);
        drive_frame(NPIX, 1, 1, 1, 0, 0);
        check_status("mid_sop", 1'b1, 1'b0);
        check_store("mid_sop_store");
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;

        // Full-length frame without EOP, then stray beats, then SOP frame with arm low
        drive_frame(NPIX, 1, 0, 1, 0, 0);
        check_status("long", 1'b0, 1'b1);
        drive_frame(40, 0, 0, 0, 0, 0);
        arm = 1'b0;
        drive_frame(NPIX, 1, 1, 1, 0, 0);
        check_status("wait_sop_unarmed", 1'b0, 1'b1);
        drive_frame(NPIX, 1, 1, 0, 0, 0);
        check_status("idle_ignored", 1'b0, 1'b1);
        check_store("long_store");

        // Reset in the middle of a frame
        arm = 1'b1;
        @(posedge clk); #1;
        drive_frame(50, 1, 0, 1, 0, 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        exp_count = 8'd0;
        chk("midreset_ready", {31'd0, ready}, 32'd0);
        check_status("midreset", 1'b0, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive_frame(30, 0, 0, 0, 0, 0);
        drive_frame(NPIX, 1, 1, 1, 0, 0);
        check_status("after_reset", 1'b0, 1'b0);
        check_store("final_store");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
